// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared CPU constants for the fetch controller.
//   - fetch_state_e   : redirect FSM encoding (RUN / PEND)
//   - EXC_VEC_DEFAULT : default exception vector used when no EPC is supplied
package fetch_ctrl_pkg;

    localparam logic [31:0] EXC_VEC_DEFAULT = 32'h0000_4180;

    typedef enum logic [0:0] {
        StRun  = 1'b0,
        StPend = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage PC redirect controller.
// Selects the next PC source with priority exception > pending redirect > new
// branch > PC+4. A branch resolved while fetch is stalled is parked in pend_pc
// and replayed on the first unstalled cycle.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   stall_req         freeze request from the hazard unit
//   br_req/br_target  taken branch/jump pulse and its target
//   exc_req/exc_target exception/interrupt/eret pulse and EPC (0 -> EXC_VEC)
//   StallF            PC hold to IF stage
//   PC_MUX_sel        1: take NPC_out_PC, 0: take PC+4
//   NPC_out_PC        redirect address (0 when PC_MUX_sel=0)
//   FlushD            clear IF/ID register
//   pend_valid        a captured branch redirect is waiting
//   err_drop          sticky: a branch redirect was discarded
//   stall_cnt         saturating count of cycles with StallF=1
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_req,
    input  logic             br_req,
    input  logic [31:0]      br_target,
    input  logic             exc_req,
    input  logic [31:0]      exc_target,
    output logic             StallF,
    output logic             PC_MUX_sel,
    output logic [31:0]      NPC_out_PC,
    output logic             FlushD,
    output logic             pend_valid,
    output logic             err_drop,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    fetch_state_e     state_q;
    logic [31:0]      pend_pc_q;
    logic             err_drop_q;
    logic [CNT_W-1:0] stall_cnt_q;

    // Output decode: purely combinational from state and inputs.
    always_comb begin
        StallF     = stall_req & ~exc_req;
        PC_MUX_sel = 1'b0;
        NPC_out_PC = 32'h0;
        FlushD     = 1'b0;
        if (exc_req) begin
            PC_MUX_sel = 1'b1;
            NPC_out_PC = (exc_target != 32'h0) ? exc_target : EXC_VEC;
            FlushD     = 1'b1;
        end else if (state_q == StPend) begin
            // Parked target replays as soon as the stall lifts.
            if (!stall_req) begin
                PC_MUX_sel = 1'b1;
                NPC_out_PC = pend_pc_q;
            end
        end else if (br_req && !stall_req) begin
            // Delay slot is kept, so no flush on a plain branch.
            PC_MUX_sel = 1'b1;
            NPC_out_PC = br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRun;
            pend_pc_q   <= 32'h0;
            err_drop_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (StallF && (stall_cnt_q != CntMax)) begin
                stall_cnt_q <= stall_cnt_q + CntOne;
            end
            if (exc_req) begin
                // Exception supersedes everything; a concurrent branch is
                // dropped silently because it belongs to the flushed path.
                state_q   <= StRun;
                pend_pc_q <= 32'h0;
            end else if (state_q == StPend) begin
                if (br_req) begin
                    err_drop_q <= 1'b1;
                end
                if (!stall_req) begin
                    state_q <= StRun;
                end
            end else if (br_req && stall_req) begin
                state_q   <= StPend;
                pend_pc_q <= br_target;
            end
        end
    end

    assign pend_valid = (state_q == StPend);
    assign err_drop   = err_drop_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        stall_req;
    logic        br_req;
    logic [31:0] br_target;
    logic        exc_req;
    logic [31:0] exc_target;

    logic        StallF, PC_MUX_sel, FlushD, pend_valid, err_drop;
    logic [31:0] NPC_out_PC;
    logic [31:0] stall_cnt;

    logic        StallF4, PC_MUX_sel4, FlushD4, pend_valid4, err_drop4;
    logic [31:0] NPC_out_PC4;
    logic [3:0]  stall_cnt4;

    int n_pass  = 0;
    int n_total = 0;

    fetch_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .stall_req  (stall_req),
        .br_req     (br_req),
        .br_target  (br_target),
        .exc_req    (exc_req),
        .exc_target (exc_target),
        .StallF     (StallF),
        .PC_MUX_sel (PC_MUX_sel),
        .NPC_out_PC (NPC_out_PC),
        .FlushD     (FlushD),
        .pend_valid (pend_valid),
        .err_drop   (err_drop),
        .stall_cnt  (stall_cnt)
    );

    fetch_ctrl #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .stall_req  (stall_req),
        .br_req     (br_req),
        .br_target  (br_target),
        .exc_req    (exc_req),
        .exc_target (exc_target),
        .StallF     (StallF4),
        .PC_MUX_sel (PC_MUX_sel4),
        .NPC_out_PC (NPC_out_PC4),
        .FlushD     (FlushD4),
        .pend_valid (pend_valid4),
        .err_drop   (err_drop4),
        .stall_cnt  (stall_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic b, input logic [31:0] bt,
                         input logic e, input logic [31:0] et);
        stall_req  = s;
        br_req     = b;
        br_target  = bt;
        exc_req    = e;
        exc_target = et;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_pend_valid", {31'h0, pend_valid}, 32'h0);
        chk("rst_err_drop",   {31'h0, err_drop},   32'h0);
        chk("rst_stall_cnt",  stall_cnt,           32'h0);
        chk("rst_sel",        {31'h0, PC_MUX_sel}, 32'h0);
        chk("rst_npc",        NPC_out_PC,          32'h0);
        chk("rst_flush",      {31'h0, FlushD},     32'h0);

        // Unstalled branch: zero-latency redirect, no flush.
        drive(1'b0, 1'b1, 32'h0000_3010, 1'b0, 32'h0);
        chk("br_sel",    {31'h0, PC_MUX_sel}, 32'h1);
        chk("br_npc",    NPC_out_PC,          32'h0000_3010);
        chk("br_flush",  {31'h0, FlushD},     32'h0);
        chk("br_stallf", {31'h0, StallF},     32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("br_pend_after", {31'h0, pend_valid}, 32'h0);
        chk("idle_sel",      {31'h0, PC_MUX_sel}, 32'h0);

        // Stalled branch held for three cycles.
        drive(1'b1, 1'b1, 32'h0000_3020, 1'b0, 32'h0);
        chk("sbr_sel",    {31'h0, PC_MUX_sel}, 32'h0);
        chk("sbr_npc",    NPC_out_PC,          32'h0);
        chk("sbr_stallf", {31'h0, StallF},     32'h1);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("sbr_pend1", {31'h0, pend_valid}, 32'h1);
        tick();
        tick();
        chk("sbr_cnt3",  stall_cnt,           32'd3);
        chk("sbr_pend3", {31'h0, pend_valid}, 32'h1);
        chk("sbr_sel3",  {31'h0, PC_MUX_sel}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("sbr_rel_sel", {31'h0, PC_MUX_sel}, 32'h1);
        chk("sbr_rel_npc", NPC_out_PC,          32'h0000_3020);
        tick();
        chk("sbr_pend_clr", {31'h0, pend_valid}, 32'h0);
        chk("sbr_cnt_hold", stall_cnt,           32'd3);

        // Exception over stall and pending, with a simultaneous branch.
        drive(1'b1, 1'b1, 32'h0000_3020, 1'b0, 32'h0);
        tick();
        chk("exc_pend_set", {31'h0, pend_valid}, 32'h1);
        drive(1'b1, 1'b1, 32'h0000_3050, 1'b1, 32'h0);
        chk("exc_stallf", {31'h0, StallF},     32'h0);
        chk("exc_sel",    {31'h0, PC_MUX_sel}, 32'h1);
        chk("exc_npc",    NPC_out_PC,          32'h0000_4180);
        chk("exc_flush",  {31'h0, FlushD},     32'h1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("exc_pend_clr", {31'h0, pend_valid}, 32'h0);
        chk("exc_no_drop",  {31'h0, err_drop},   32'h0);
        chk("exc_cnt",      stall_cnt,           32'd4);

        // eret with explicit EPC.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_2000);
        chk("eret_npc",   NPC_out_PC,      32'h0000_2000);
        chk("eret_flush", {31'h0, FlushD}, 32'h1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("eret_flush_off", {31'h0, FlushD}, 32'h0);

        // Drop: new branch while pending.
        drive(1'b1, 1'b1, 32'h0000_3020, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 32'h0000_3040, 1'b0, 32'h0);
        chk("drop_sel", {31'h0, PC_MUX_sel}, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("drop_err",      {31'h0, err_drop}, 32'h1);
        chk("drop_keep_npc", NPC_out_PC,        32'h0000_3020);
        tick();
        chk("drop_pend_clr", {31'h0, pend_valid}, 32'h0);
        chk("drop_sticky",   {31'h0, err_drop},   32'h1);

        // PEND->RUN with simultaneous branch: older target wins.
        drive(1'b1, 1'b1, 32'h0000_3060, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 32'h0000_3070, 1'b0, 32'h0);
        chk("old_wins_npc", NPC_out_PC, 32'h0000_3060);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("old_wins_pend", {31'h0, pend_valid}, 32'h0);
        chk("old_wins_cnt",  stall_cnt,           32'd7);

        // Reset mid-operation from PEND with a concurrent branch.
        drive(1'b1, 1'b1, 32'h0000_3080, 1'b0, 32'h0);
        tick();
        chk("pre_rst_pend", {31'h0, pend_valid}, 32'h1);
        reset = 1'b1;
        drive(1'b1, 1'b1, 32'h0000_3090, 1'b0, 32'h0);
        chk("in_rst_stallf", {31'h0, StallF}, 32'h1);
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("mrst_pend", {31'h0, pend_valid}, 32'h0);
        chk("mrst_err",  {31'h0, err_drop},   32'h0);
        chk("mrst_cnt",  stall_cnt,           32'h0);
        chk("mrst_sel",  {31'h0, PC_MUX_sel}, 32'h0);

        // Saturation on the 4-bit instance.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 14; i++) tick();
        chk("sat_cnt14", {28'h0, stall_cnt4}, 32'hE);
        for (int i = 0; i < 6; i++) tick();
        chk("sat_cnt20",  {28'h0, stall_cnt4}, 32'hF);
        chk("wide_cnt20", stall_cnt,           32'd20);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
